// File: rtl/rggen_rtl_pkg.sv
// Shared access/status encodings used by every rggen bus port.
// Only the enum types this slice needs are declared here.
package rggen_rtl_pkg;

   typedef enum logic [1:0] {
      RGGEN_WRITE        = 2'b01,
      RGGEN_READ         = 2'b10,
      RGGEN_POSTED_WRITE = 2'b11
   } rggen_access;

   typedef enum logic [1:0] {
      RGGEN_OKAY         = 2'b00,
      RGGEN_EXOKAY       = 2'b01,
      RGGEN_SLAVE_ERROR  = 2'b10,
      RGGEN_DECODE_ERROR = 2'b11
   } rggen_status;

endpackage

// File: rtl/rggen_bus_if.sv
// Native rggen request/response bus, shared by host side and csrbus side.
// Handshake: a request is held stable while valid=1; the transfer completes in the cycle ready=1.
interface rggen_bus_if
   import rggen_rtl_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8,
   parameter int BUS_WIDTH     = 32,
   parameter int STROBE_WIDTH  = BUS_WIDTH / 8
);

   logic                     valid;
   rggen_access              access;
   logic [ADDRESS_WIDTH-1:0] address;
   logic [BUS_WIDTH-1:0]     write_data;
   logic [STROBE_WIDTH-1:0]  strobe;
   logic                     ready;
   rggen_status              status;
   logic [BUS_WIDTH-1:0]     read_data;

   modport master (
      output valid, access, address, write_data, strobe,
      input  ready, status, read_data
   );

   modport slave (
      input  valid, access, address, write_data, strobe,
      output ready, status, read_data
   );

endinterface

// File: rtl/rggen_native_request_slice.sv
// Registers one host request, replays it on the csrbus and returns a registered response.
// An optional watchdog aborts a stalled csrbus access with a SLAVE_ERROR response.
module rggen_native_request_slice
   import rggen_rtl_pkg::*;
#(
   parameter int                   ADDRESS_WIDTH     = 8,
   parameter int                   BUS_WIDTH         = 32,
   parameter int                   STROBE_WIDTH      = BUS_WIDTH / 8,
   parameter int                   TIMEOUT_CYCLES    = 0,
   parameter logic [BUS_WIDTH-1:0] TIMEOUT_READ_DATA = '0
)(
   input  logic        i_clk,
   input  logic        i_rst,
   rggen_bus_if.slave  host_if,
   rggen_bus_if.master csrbus_if,
   output logic        o_timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RESPOND = 2'd2
   } state_e;

   state_e                   state_q;
   state_e                   state_d;
   rggen_access              access_q;
   logic [ADDRESS_WIDTH-1:0] address_q;
   logic [BUS_WIDTH-1:0]     write_data_q;
   logic [STROBE_WIDTH-1:0]  strobe_q;
   rggen_status              status_q;
   logic [BUS_WIDTH-1:0]     read_data_q;
   logic                     timeout_q;
   logic                     expire;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Ready is checked before expiry so a response on the last watchdog cycle wins.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (host_if.valid) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (csrbus_if.ready || expire) begin
               state_d = RESPOND;
            end
         end
         RESPOND: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if ((state_q == IDLE) && host_if.valid) begin
         access_q     <= host_if.access;
         address_q    <= host_if.address;
         write_data_q <= host_if.write_data;
         strobe_q     <= host_if.strobe;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         status_q    <= RGGEN_OKAY;
         read_data_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         if ((state_q == ISSUE) && csrbus_if.ready) begin
            status_q    <= csrbus_if.status;
            read_data_q <= csrbus_if.read_data;
         end else if (expire) begin
            status_q    <= RGGEN_SLAVE_ERROR;
            read_data_q <= TIMEOUT_READ_DATA;
            timeout_q   <= 1'b1;
         end
      end
   end

   if (TIMEOUT_CYCLES > 0) begin : g_watchdog
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] count_q;

      // Saturates at the limit; the state machine leaves ISSUE on that cycle anyway.
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            count_q <= '0;
         end else if (state_q != ISSUE) begin
            count_q <= '0;
         end else if (!csrbus_if.ready && (count_q != CW'(TIMEOUT_CYCLES - 1))) begin
            count_q <= count_q + CW'(1);
         end
      end

      assign expire = (state_q == ISSUE) && (count_q == CW'(TIMEOUT_CYCLES - 1));
   end else begin : g_no_watchdog
      assign expire = 1'b0;
   end

   assign csrbus_if.valid      = (state_q == ISSUE);
   assign csrbus_if.access     = access_q;
   assign csrbus_if.address    = address_q;
   assign csrbus_if.write_data = write_data_q;
   assign csrbus_if.strobe     = strobe_q;

   assign host_if.ready     = (state_q == RESPOND);
   assign host_if.status    = status_q;
   assign host_if.read_data = read_data_q;

   assign o_timeout = timeout_q;

endmodule

// File: tb/tb_rggen_native_request_slice.sv
// Bench for rggen_native_request_slice: a watchdog-enabled instance driven by a
// latency-programmable adapter model, plus a watchdog-less instance for the unbounded wait.
module tb_rggen_native_request_slice;
   import rggen_rtl_pkg::*;

   localparam int             AW    = 8;
   localparam int             DW    = 32;
   localparam int             SW    = 4;
   localparam int             TO    = 4;
   localparam logic [DW-1:0]  TO_RD = 32'hBAD0_0BAD;
   localparam int             RW    = 2 + AW + DW + SW;
   localparam int             EW    = 2 + DW + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   logic timeout;
   logic timeout0;

   always #5 clk = ~clk;

   rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) bus_h  ();
   rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) bus_c  ();
   rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) bus_h0 ();
   rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) bus_c0 ();

   rggen_native_request_slice #(
      .ADDRESS_WIDTH(AW), .BUS_WIDTH(DW), .STROBE_WIDTH(SW),
      .TIMEOUT_CYCLES(TO), .TIMEOUT_READ_DATA(TO_RD)
   ) dut (
      .i_clk(clk), .i_rst(rst), .host_if(bus_h), .csrbus_if(bus_c), .o_timeout(timeout)
   );

   rggen_native_request_slice #(
      .ADDRESS_WIDTH(AW), .BUS_WIDTH(DW), .STROBE_WIDTH(SW), .TIMEOUT_CYCLES(0)
   ) dut0 (
      .i_clk(clk), .i_rst(rst), .host_if(bus_h0), .csrbus_if(bus_c0), .o_timeout(timeout0)
   );

   // ---------------- bench state / scoreboard ----------------
   int          assert_cnt = 0;
   int          fail_cnt   = 0;
   int          adapter_lat = -1;
   rggen_status adapter_st  = RGGEN_OKAY;
   logic [DW-1:0] adapter_rd = '0;
   bit          late_ready = 1'b0;
   int          c_cycle = 0;
   int          phases = 0;
   int          valid_cycles = 0;
   int          to_pulses = 0;
   int          stab_err = 0;
   logic [RW-1:0] cur_req;
   logic [RW-1:0] obs_q[$];
   logic [RW-1:0] exp_req_q[$];
   logic [EW-1:0] exp_q[$];
   rggen_access acc_tbl[3] = '{RGGEN_READ, RGGEN_WRITE, RGGEN_POSTED_WRITE};

   // One cycle step: sample at negedge, then play the csrbus adapter for the next edge.
   task automatic tick();
      @(negedge clk);
      if (timeout === 1'b1) to_pulses++;
      if (bus_c.valid === 1'b1) begin
         valid_cycles++;
         if (c_cycle == 0) begin
            cur_req = {bus_c.access, bus_c.address, bus_c.write_data, bus_c.strobe};
            obs_q.push_back(cur_req);
            phases++;
         end else if ({bus_c.access, bus_c.address, bus_c.write_data, bus_c.strobe} !== cur_req) begin
            stab_err++;
         end
         bus_c.ready = late_ready || ((adapter_lat >= 0) && (c_cycle == adapter_lat));
         c_cycle++;
      end else begin
         bus_c.ready = late_ready;
         c_cycle = 0;
      end
      bus_c.status    = adapter_st;
      bus_c.read_data = adapter_rd;
      late_ready = 1'b0;
   endtask

   // ---------------- driver ----------------
   // Called at a negedge with the slice in IDLE or RESPOND; returns at the host ready cycle
   // with host valid still asserted.
   task automatic do_transfer(input rggen_access acc, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wd, input logic [SW-1:0] sb,
                              input int lat, input rggen_status st, input logic [DW-1:0] rd);
      int n;
      int exp_n;
      bit got;
      logic [EW-1:0] resp;
      logic [RW-1:0] req;
      bus_h.valid      = 1'b1;
      bus_h.access     = acc;
      bus_h.address    = addr;
      bus_h.write_data = wd;
      bus_h.strobe     = sb;
      adapter_lat = lat;
      adapter_st  = st;
      adapter_rd  = rd;
      if ((lat >= 0) && (lat < TO)) begin
         exp_n = lat + 2;
         exp_q.push_back({st, rd, 1'b0});
      end else begin
         exp_n = TO + 1;
         exp_q.push_back({RGGEN_SLAVE_ERROR, TO_RD, 1'b1});
      end
      exp_req_q.push_back({acc, addr, wd, sb});
      if (bus_h.ready === 1'b1) tick();
      n = 0;
      got = 1'b0;
      while (!got && (n < 32)) begin
         tick();
         n++;
         got = (bus_h.ready === 1'b1);
      end
      assert_cnt++;
      if (!got || (n != exp_n)) begin
         fail_cnt++;
         $display("FAIL latency: host ready after %0d cycles (seen=%0d), expected %0d", n, got, exp_n);
      end
      resp = exp_q.pop_front();
      assert_cnt++;
      if ({bus_h.status, bus_h.read_data, timeout} !== resp) begin
         fail_cnt++;
         $display("FAIL response: got status=%0h data=%h timeout=%b, expected status=%0h data=%h timeout=%b",
                  bus_h.status, bus_h.read_data, timeout, resp[EW-1 -: 2], resp[DW:1], resp[0]);
      end
      req = exp_req_q.pop_front();
      assert_cnt++;
      if (obs_q.size() == 0) begin
         fail_cnt++;
         $display("FAIL csr_request: no csrbus request observed, expected %h", req);
      end else if (obs_q[0] !== req) begin
         fail_cnt++;
         $display("FAIL csr_request: got %h, expected %h", obs_q[0], req);
      end
      if (obs_q.size() != 0) void'(obs_q.pop_front());
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      assert_cnt++;
      if ({bus_c.valid, bus_h.ready, timeout, bus_c0.valid, bus_h0.ready} !== 5'b0) begin
         fail_cnt++;
         $display("FAIL reset_ctrl: got %b, expected 00000",
                  {bus_c.valid, bus_h.ready, timeout, bus_c0.valid, bus_h0.ready});
      end
      assert_cnt++;
      if ({bus_h.status, bus_h.read_data} !== {RGGEN_OKAY, 32'h0}) begin
         fail_cnt++;
         $display("FAIL reset_resp: got status=%0h data=%h, expected 0/0", bus_h.status, bus_h.read_data);
      end
      rst = 1'b0;
      tick();
      assert_cnt++;
      if ({bus_c.valid, bus_h.ready} !== 2'b00) begin
         fail_cnt++;
         $display("FAIL reset_idle: got %b, expected 00", {bus_c.valid, bus_h.ready});
      end
   endtask

   task automatic test_read();
      do_transfer(RGGEN_READ, 8'h10, 32'h0, 4'h0, 1, RGGEN_OKAY, 32'hDEAD_BEEF);
      tick();
      bus_h.valid = 1'b0;
      repeat (3) begin
         tick();
         assert_cnt++;
         if ({bus_h.ready, bus_h.status, bus_h.read_data} !== {1'b0, RGGEN_OKAY, 32'hDEAD_BEEF}) begin
            fail_cnt++;
            $display("FAIL hold_resp: got ready=%b status=%0h data=%h, expected 0/0/deadbeef",
                     bus_h.ready, bus_h.status, bus_h.read_data);
         end
      end
   endtask

   task automatic test_write_pair();
      int p0;
      p0 = phases;
      do_transfer(RGGEN_WRITE, 8'h24, 32'h1122_3344, 4'hF, 0, RGGEN_OKAY, 32'h0);
      do_transfer(RGGEN_WRITE, 8'h28, 32'h5566_7788, 4'hF, 2, RGGEN_OKAY, 32'h0);
      tick();
      bus_h.valid = 1'b0;
      repeat (4) tick();
      assert_cnt++;
      if (phases - p0 != 2) begin
         fail_cnt++;
         $display("FAIL write_phases: got %0d csrbus phases, expected 2", phases - p0);
      end
   endtask

   task automatic test_error_status();
      do_transfer(RGGEN_READ, 8'h30, 32'h0, 4'h0, 0, RGGEN_SLAVE_ERROR, 32'h0BAD_F00D);
      tick();
      bus_h.valid = 1'b0;
      tick();
      do_transfer(RGGEN_WRITE, 8'hFC, 32'hCAFE_0001, 4'h3, 2, RGGEN_DECODE_ERROR, 32'h0);
      tick();
      bus_h.valid = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int v0;
      int t0;
      int p0;
      v0 = valid_cycles;
      t0 = to_pulses;
      do_transfer(RGGEN_READ, 8'h44, 32'h0, 4'h0, -1, RGGEN_OKAY, 32'h1234_5678);
      p0 = phases;
      assert_cnt++;
      if (valid_cycles - v0 != TO) begin
         fail_cnt++;
         $display("FAIL timeout_valid_len: got %0d, expected %0d", valid_cycles - v0, TO);
      end
      late_ready = 1'b1;
      tick();
      bus_h.valid = 1'b0;
      repeat (4) begin
         tick();
         assert_cnt++;
         if ({bus_h.ready, bus_c.valid, bus_h.status, bus_h.read_data} !==
             {1'b0, 1'b0, RGGEN_SLAVE_ERROR, TO_RD}) begin
            fail_cnt++;
            $display("FAIL late_ready: got hready=%b cvalid=%b status=%0h data=%h, expected 0/0/2/%h",
                     bus_h.ready, bus_c.valid, bus_h.status, bus_h.read_data, TO_RD);
         end
      end
      assert_cnt++;
      if ((to_pulses - t0 != 1) || (phases != p0)) begin
         fail_cnt++;
         $display("FAIL timeout_pulses: got pulses=%0d extra_phases=%0d, expected 1/0",
                  to_pulses - t0, phases - p0);
      end
   endtask

   task automatic test_ready_at_limit();
      int t0;
      t0 = to_pulses;
      do_transfer(RGGEN_READ, 8'h48, 32'h0, 4'h0, TO - 1, RGGEN_EXOKAY, 32'hA5A5_5A5A);
      tick();
      bus_h.valid = 1'b0;
      tick();
      assert_cnt++;
      if (to_pulses != t0) begin
         fail_cnt++;
         $display("FAIL ready_at_limit: got %0d timeout pulses, expected 0", to_pulses - t0);
      end
   endtask

   task automatic test_reset_mid();
      bus_h.valid      = 1'b1;
      bus_h.access     = RGGEN_WRITE;
      bus_h.address    = 8'h50;
      bus_h.write_data = 32'h0F0F_0F0F;
      bus_h.strobe     = 4'h1;
      adapter_lat = -1;
      tick();
      tick();
      assert_cnt++;
      if (bus_c.valid !== 1'b1) begin
         fail_cnt++;
         $display("FAIL mid_issue_pre: csrbus valid=%b, expected 1", bus_c.valid);
      end
      rst = 1'b1;
      #1;
      assert_cnt++;
      if ({bus_c.valid, bus_h.ready, bus_h.status, bus_h.read_data} !== {1'b0, 1'b0, RGGEN_OKAY, 32'h0}) begin
         fail_cnt++;
         $display("FAIL reset_mid_issue: got cvalid=%b hready=%b status=%0h data=%h, expected 0/0/0/0",
                  bus_c.valid, bus_h.ready, bus_h.status, bus_h.read_data);
      end
      bus_h.valid = 1'b0;
      obs_q.delete();
      tick();
      tick();
      rst = 1'b0;
      do_transfer(RGGEN_READ, 8'h54, 32'h0, 4'h0, 0, RGGEN_DECODE_ERROR, 32'h7777_0000);
      rst = 1'b1;
      #1;
      assert_cnt++;
      if ({bus_h.ready, timeout, bus_h.status} !== {1'b0, 1'b0, RGGEN_OKAY}) begin
         fail_cnt++;
         $display("FAIL reset_mid_respond: got hready=%b timeout=%b status=%0h, expected 0/0/0",
                  bus_h.ready, timeout, bus_h.status);
      end
      bus_h.valid = 1'b0;
      tick();
      rst = 1'b0;
      do_transfer(RGGEN_READ, 8'h58, 32'h0, 4'h0, 1, RGGEN_OKAY, 32'h600D_600D);
      tick();
      bus_h.valid = 1'b0;
      tick();
   endtask

   task automatic test_random();
      int p0;
      int t0;
      int exp_to;
      int lat;
      p0 = phases;
      t0 = to_pulses;
      exp_to = 0;
      stab_err = 0;
      for (int i = 0; i < 40; i++) begin
         lat = $urandom_range(0, 5);
         if (lat == 5) lat = -1;
         if ((lat < 0) || (lat >= TO)) exp_to++;
         do_transfer(acc_tbl[$urandom_range(0, 2)], AW'($urandom), DW'($urandom), SW'($urandom),
                     lat, rggen_status'(2'($urandom_range(0, 3))), DW'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            tick();
            bus_h.valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
         end
      end
      tick();
      bus_h.valid = 1'b0;
      repeat (3) tick();
      assert_cnt++;
      if (phases - p0 != 40) begin
         fail_cnt++;
         $display("FAIL random_phases: got %0d, expected 40", phases - p0);
      end
      assert_cnt++;
      if (to_pulses - t0 != exp_to) begin
         fail_cnt++;
         $display("FAIL random_timeouts: got %0d, expected %0d", to_pulses - t0, exp_to);
      end
      assert_cnt++;
      if ((stab_err != 0) || (obs_q.size() != 0)) begin
         fail_cnt++;
         $display("FAIL random_stability: got unstable=%0d leftover=%0d, expected 0/0", stab_err, obs_q.size());
      end
   endtask

   task automatic test_no_timeout();
      int vc;
      int rdy;
      int tp;
      bus_h0.valid      = 1'b1;
      bus_h0.access     = RGGEN_POSTED_WRITE;
      bus_h0.address    = 8'h9C;
      bus_h0.write_data = 32'h0123_4567;
      bus_h0.strobe     = 4'hC;
      tick();
      vc = 0;
      rdy = 0;
      tp = 0;
      repeat (12) begin
         tick();
         if (bus_c0.valid === 1'b1) vc++;
         if (bus_h0.ready === 1'b1) rdy++;
         if (timeout0 === 1'b1) tp++;
      end
      assert_cnt++;
      if ((vc != 12) || (rdy != 0) || (tp != 0)) begin
         fail_cnt++;
         $display("FAIL no_timeout_wait: got valid=%0d ready=%0d timeout=%0d, expected 12/0/0", vc, rdy, tp);
      end
      assert_cnt++;
      if ({bus_c0.access, bus_c0.address, bus_c0.write_data, bus_c0.strobe} !==
          {RGGEN_POSTED_WRITE, 8'h9C, 32'h0123_4567, 4'hC}) begin
         fail_cnt++;
         $display("FAIL no_timeout_req: got %h, expected %h",
                  {bus_c0.access, bus_c0.address, bus_c0.write_data, bus_c0.strobe},
                  {RGGEN_POSTED_WRITE, 8'h9C, 32'h0123_4567, 4'hC});
      end
      bus_c0.status    = RGGEN_EXOKAY;
      bus_c0.read_data = 32'hFEED_F00D;
      bus_c0.ready     = 1'b1;
      tick();
      bus_c0.ready = 1'b0;
      assert_cnt++;
      if ({bus_h0.ready, bus_h0.status, bus_h0.read_data} !== {1'b1, RGGEN_EXOKAY, 32'hFEED_F00D}) begin
         fail_cnt++;
         $display("FAIL no_timeout_resp: got ready=%b status=%0h data=%h, expected 1/1/feedf00d",
                  bus_h0.ready, bus_h0.status, bus_h0.read_data);
      end
      tick();
      bus_h0.valid = 1'b0;
      repeat (2) tick();
      assert_cnt++;
      if ({bus_c0.valid, bus_h0.ready} !== 2'b00) begin
         fail_cnt++;
         $display("FAIL no_timeout_idle: got %b, expected 00", {bus_c0.valid, bus_h0.ready});
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      bus_h.valid = 1'b0;  bus_h.access = RGGEN_READ;  bus_h.address = '0;
      bus_h.write_data = '0;  bus_h.strobe = '0;
      bus_c.ready = 1'b0;  bus_c.status = RGGEN_OKAY;  bus_c.read_data = '0;
      bus_h0.valid = 1'b0; bus_h0.access = RGGEN_READ; bus_h0.address = '0;
      bus_h0.write_data = '0; bus_h0.strobe = '0;
      bus_c0.ready = 1'b0; bus_c0.status = RGGEN_OKAY; bus_c0.read_data = '0;
      test_reset();
      test_read();
      test_write_pair();
      test_error_status();
      test_timeout();
      test_ready_at_limit();
      test_reset_mid();
      test_random();
      test_no_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation ran past 200000 time units, expected completion");
      $fatal(1, "bench time limit reached");
   end

endmodule

// File: doc/rggen_native_request_slice.md
RGGEN_NATIVE_REQUEST_SLICE -- requirements
Module: rggen_native_request_slice

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8: address width on both bus ports.
REQ-002 SHALL have parameter BUS_WIDTH, default 32: data width on both bus ports.
REQ-003 SHALL have parameter STROBE_WIDTH, default BUS_WIDTH/8: byte-strobe width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 0: watchdog limit in cycles; 0 disables the watchdog.
REQ-005 SHALL have parameter TIMEOUT_READ_DATA, default all-zero, BUS_WIDTH bits: read data returned on a timeout.
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port host_if, rggen_bus_if.slave: upstream host request and response.
REQ-009 SHALL have port csrbus_if, rggen_bus_if.master: downstream native bus into the native adapter.
REQ-010 SHALL have port o_timeout, output, 1 bit: one-cycle pulse when a watchdog abort occurs.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE and RESPOND.
REQ-012 In IDLE with host_if.valid=1, SHALL capture access, address, write_data and strobe into registers at the clock edge and move to ISSUE.
REQ-013 In ISSUE, SHALL drive csrbus_if.valid=1 and csrbus_if.access/address/write_data/strobe from the captured registers, held stable for the whole state.
REQ-014 In ISSUE with csrbus_if.ready=1, SHALL register csrbus_if.status/read_data, deassert csrbus_if.valid in the next cycle, and move to RESPOND.
REQ-015 In RESPOND, SHALL drive host_if.ready=1 for exactly one cycle with the registered status/read_data, then return to IDLE.
REQ-016 SHALL ignore host_if.valid while in ISSUE and RESPOND; the host's still-asserted valid during its ready cycle SHALL NOT start a new transfer.
REQ-017 SHALL ignore csrbus_if.ready outside ISSUE, including a late ready after a timeout abort.
REQ-018 Latency: host valid sampled at edge N gives csrbus valid in cycle N+1; csrbus ready in cycle M gives host ready in cycle M+1.
REQ-019 Back-to-back: a host valid present in the first IDLE cycle after RESPOND SHALL be captured in that cycle.
REQ-020 Watchdog (TIMEOUT_CYCLES>0): SHALL clear a counter on entry to ISSUE and increment it each ISSUE cycle without csrbus ready.
REQ-021 When the counter equals TIMEOUT_CYCLES-1 with no ready, SHALL deassert csrbus valid next cycle, load status RGGEN_SLAVE_ERROR and TIMEOUT_READ_DATA, pulse o_timeout, and enter RESPOND.
REQ-022 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1) bits and the counter SHALL never wrap.
REQ-023 Ready and timeout in the same cycle: ready SHALL win, returning the real response with no o_timeout pulse.
REQ-024 When TIMEOUT_CYCLES=0, the counter logic SHALL be absent and ISSUE SHALL wait indefinitely.
REQ-025 host_if.status/read_data SHALL be held at their last values outside RESPOND.

Reset
REQ-026 Asserting i_rst at any time, including mid-ISSUE or mid-RESPOND, SHALL force IDLE immediately.
REQ-027 Reset SHALL set csrbus_if.valid=0, host_if.ready=0, o_timeout=0 and counter=0.
REQ-028 Reset SHALL set host_if.status=RGGEN_OKAY and host_if.read_data=0; captured request registers need no reset.
REQ-029 In the first cycle after deassertion, SHALL be in IDLE and able to capture a request.

Structure
REQ-030 SHALL use rggen_rtl_pkg rggen_access/rggen_status types.
REQ-031 The state enum SHALL be declared locally, with no new package content.
REQ-032 SHALL contain no sub-modules; it is a single flat module placed upstream of rggen_native_adapter.

Verification
REQ-033 Read, adapter ready 1 cycle after valid, address 0x10, data 0xDEADBEEF: host ready 3 cycles after host valid with OKAY and 0xDEADBEEF.
REQ-034 Write with strobe 0xF, then an immediate second write: exactly two csrbus valid phases; host valid held through its ready cycle causes no extra transfer.
REQ-035 TIMEOUT_CYCLES=4, adapter never ready: csrbus valid high for exactly 4 cycles, then o_timeout pulse and host ready with SLAVE_ERROR and TIMEOUT_READ_DATA; a late ready 1 cycle later is ignored.
REQ-036 TIMEOUT_CYCLES=4, ready in the 4th ISSUE cycle: real response returned, o_timeout stays 0.
REQ-037 i_rst asserted mid-ISSUE: csrbus valid and host ready drop immediately; a request issued after deassertion completes normally.
REQ-038 Adapter returns SLAVE_ERROR/DECODE_ERROR: status passed to the host unchanged.
